pwm_meas: RTL and testbench

Measures the on-time, off-time and period of a PWM waveform in emulated time by integrating the per-cycle timestep `dt` between level transitions of a logic input. It sits directly downstream of the `pwm` generator, or any switching-state output, and provides real-valued measurements for duty/frequency checks and closed-loop controllers in the emulator. Outputs are fixed-point reals built with the standard real macros.

---
 rtl/pwm_meas.sv | 148 ++++++++++++++
 tb/tb_pwm_meas.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_meas.sv
// pwm_meas: measures the on-time, off-time and period of a PWM level by summing the per-cycle
// emulated timestep dt between level transitions.
//
// Times are unsigned fixed-point reals with an LSB of dt_lsb seconds. t_max sets the range of
// the accumulator and of t_on/t_off; period carries one extra bit (range 2*t_max).
//
// Ports:
//   clk    - system clock; each rising edge advances emulated time by dt
//   rst    - synchronous, active-high reset
//   dt     - emulated time elapsed this cycle (DtW bits, LSB = dt_lsb)
//   in     - PWM level under measurement
//   t_on   - last measured high-phase duration
//   t_off  - last measured low-phase duration
//   period - t_on + t_off of the last complete period
//   valid  - one-cycle pulse when period is updated
//   stuck  - level held longer than t_max; measurement restarted
module pwm_meas #(
  parameter real         t_max  = 1e-3,
  parameter real         dt_lsb = 1e-12,
  parameter int unsigned DtW    = 16,
  localparam longint      TMaxCnt = longint'(t_max / dt_lsb),
  localparam int unsigned AccW    = $clog2(TMaxCnt + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DtW-1:0]  dt,
  input  logic            in,
  output logic [AccW-1:0] t_on,
  output logic [AccW-1:0] t_off,
  output logic [AccW:0]   period,
  output logic            valid,
  output logic            stuck
);

  // One guard bit so acc + dt can be compared against t_max without wrapping.
  localparam int unsigned     SumW = ((AccW > DtW) ? AccW : DtW) + 1;
  localparam logic [SumW-1:0] TMax = SumW'(TMaxCnt);

  typedef enum logic [1:0] {StInit, StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic              level_q, level_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic              have_on_q, have_on_d;
  logic              have_off_q, have_off_d;
  logic [AccW-1:0]   t_on_q, t_on_d;
  logic [AccW-1:0]   t_off_q, t_off_d;
  logic [AccW:0]     period_q, period_d;
  logic              valid_q, valid_d;
  logic              stuck_q, stuck_d;

  logic              trans;
  logic [SumW-1:0]   acc_sum;
  logic [AccW-1:0]   dt_acc;

  assign trans   = (in != level_q);
  assign acc_sum = SumW'(acc_q) + SumW'(dt);
  assign dt_acc  = AccW'(dt);

  always_comb begin
    state_d    = state_q;
    level_d    = in;
    acc_d      = acc_q;
    have_on_d  = have_on_q;
    have_off_d = have_off_q;
    t_on_d     = t_on_q;
    t_off_d    = t_off_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    stuck_d    = stuck_q;

    case (state_q)
      StInit: begin
        state_d = StIdle;
      end
      StIdle: begin
        // The partial phase before the first transition is discarded.
        acc_d = '0;
        if (trans) begin
          acc_d   = dt_acc;
          stuck_d = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (trans) begin
          // The transition cycle's dt opens the new phase.
          acc_d = dt_acc;
          if (level_q) begin
            t_on_d    = acc_q;
            have_on_d = 1'b1;
          end else begin
            t_off_d    = acc_q;
            have_off_d = 1'b1;
            if (have_on_q) begin
              period_d = {1'b0, t_on_q} + {1'b0, acc_q};
              valid_d  = 1'b1;
            end
          end
        end else if (acc_sum > TMax) begin
          stuck_d    = 1'b1;
          state_d    = StIdle;
          acc_d      = '0;
          have_on_d  = 1'b0;
          have_off_d = 1'b0;
        end else begin
          acc_d = AccW'(acc_sum);
        end
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit;
      level_q    <= 1'b0;
      acc_q      <= '0;
      have_on_q  <= 1'b0;
      have_off_q <= 1'b0;
      t_on_q     <= '0;
      t_off_q    <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      acc_q      <= acc_d;
      have_on_q  <= have_on_d;
      have_off_q <= have_off_d;
      t_on_q     <= t_on_d;
      t_off_q    <= t_off_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      stuck_q    <= stuck_d;
    end
  end

  assign t_on   = t_on_q;
  assign t_off  = t_off_q;
  assign period = period_q;
  assign valid  = valid_q;
  assign stuck  = stuck_q;

endmodule

// File: tb/tb_pwm_meas.sv
// Bench for pwm_meas with t_max = 2 us and a 1 ps time LSB. A phase-level reference model
// (completed high phases kept in a queue) predicts every output after every clock edge.
module tb_pwm_meas;

  localparam int unsigned     DW   = 16;
  localparam int unsigned     AW   = 21;      // ceil(log2(2e6 + 1))
  localparam int unsigned     PW   = 22;
  localparam longint unsigned TMAX = 2000000; // 2 us in ps

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_s = 1'b0;
  logic [DW-1:0] dt_s = '0;
  logic [AW-1:0] t_on, t_off;
  logic [PW-1:0] period;
  logic          valid, stuck;

  pwm_meas #(.t_max(2e-6), .dt_lsb(1e-12), .DtW(DW)) dut (
    .clk(clk), .rst(rst), .dt(dt_s), .in(in_s),
    .t_on(t_on), .t_off(t_off), .period(period), .valid(valid), .stuck(stuck)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state.
  bit              m_started, m_meas, m_prev;
  longint unsigned m_sum;
  longint unsigned highs[$];
  longint unsigned m_t_on, m_t_off, m_period;
  bit              m_valid, m_stuck;

  task automatic model_step();
    m_valid = 1'b0;
    if (rst) begin
      m_started = 0; m_meas = 0; m_prev = 0; m_sum = 0; highs.delete();
      m_t_on = 0; m_t_off = 0; m_period = 0; m_stuck = 0;
      return;
    end
    if (!m_started) begin
      m_started = 1;
      m_prev = in_s;
      return;
    end
    if (!m_meas) begin
      if (in_s != m_prev) begin
        m_meas = 1; m_sum = dt_s; m_stuck = 0; highs.delete();
      end
    end else if (in_s != m_prev) begin
      if (m_prev) begin
        m_t_on = m_sum;
        highs.push_back(m_sum);
      end else begin
        m_t_off = m_sum;
        if (highs.size() > 0) begin
          m_period = highs[$] + m_sum;
          m_valid = 1;
        end
      end
      m_sum = dt_s;
    end else if (m_sum + dt_s > TMAX) begin
      m_stuck = 1; m_meas = 0; m_sum = 0; highs.delete();
    end else begin
      m_sum = m_sum + dt_s;
    end
    m_prev = in_s;
  endtask

  task automatic tick(input logic r, input logic lv, input int unsigned d);
    rst = r; in_s = lv; dt_s = DW'(d);
    @(posedge clk);
    model_step();
    #1;
    cyc++;
  endtask

  function automatic string got_want();
    return $sformatf("got on=%0d off=%0d per=%0d v=%b s=%b want on=%0d off=%0d per=%0d v=%b s=%b",
                     t_on, t_off, period, valid, stuck, m_t_on, m_t_off, m_period, m_valid, m_stuck);
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 10000);
    if (t_on !== '0 || t_off !== '0 || period !== '0 || valid !== 1'b0 || stuck !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: got on=%0d off=%0d per=%0d v=%b s=%b want all 0",
               t_on, t_off, period, valid, stuck);
    end
    checks++;
  endtask

  task automatic test_low_start();
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 10000);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 10000);
    for (int p = 0; p < 3; p++) begin
      for (int ph = 0; ph < 2; ph++) begin
        for (int j = 0; j < (ph == 0 ? 30 : 70); j++) begin
          tick(1'b0, (ph == 0), 10000);
          if (t_on !== AW'(m_t_on) || t_off !== AW'(m_t_off) || period !== PW'(m_period) ||
              valid !== m_valid || stuck !== m_stuck) begin
            failures++;
            $display("FAIL low_start cyc %0d: %s", cyc, got_want());
          end
          checks++;
          if (p >= 1 && ph == 0 && j == 0) begin
            if (t_on !== AW'(300000) || t_off !== AW'(700000) || period !== PW'(1000000) ||
                valid !== 1'b1) begin
              failures++;
              $display("FAIL low_start_period p%0d: got on=%0d off=%0d per=%0d v=%b want 300000 700000 1000000 1",
                       p, t_on, t_off, period, valid);
            end
            checks++;
          end
        end
      end
    end
  endtask

  task automatic test_high_start();
    int lv[5]  = '{1, 0, 1, 0, 1};
    int len[5] = '{10, 70, 30, 70, 5};
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b1, 10000);
    for (int ph = 0; ph < 5; ph++) begin
      for (int j = 0; j < len[ph]; j++) begin
        tick(1'b0, lv[ph][0], 10000);
        if (t_on !== AW'(m_t_on) || t_off !== AW'(m_t_off) || period !== PW'(m_period) ||
            valid !== m_valid || stuck !== m_stuck) begin
          failures++;
          $display("FAIL high_start cyc %0d: %s", cyc, got_want());
        end
        checks++;
        if (ph == 2 && j == 0) begin
          if (t_off !== AW'(700000) || valid !== 1'b0) begin
            failures++;
            $display("FAIL high_start_first_low: got off=%0d v=%b want 700000 0", t_off, valid);
          end
          checks++;
        end
        if (ph == 4 && j == 0) begin
          if (t_on !== AW'(300000) || period !== PW'(1000000) || valid !== 1'b1) begin
            failures++;
            $display("FAIL high_start_first_valid: got on=%0d per=%0d v=%b want 300000 1000000 1",
                     t_on, period, valid);
          end
          checks++;
        end
      end
    end
  endtask

  task automatic test_variable_dt();
    int k = 0;
    for (int p = 0; p < 5; p++) begin
      for (int j = 0; j < 10; j++) begin
        tick(1'b0, (j < 4), (k % 2 == 0) ? 5000 : 15000);
        k++;
        if (t_on !== AW'(m_t_on) || t_off !== AW'(m_t_off) || period !== PW'(m_period) ||
            valid !== m_valid || stuck !== m_stuck) begin
          failures++;
          $display("FAIL variable_dt cyc %0d: %s", cyc, got_want());
        end
        checks++;
      end
    end
    tick(1'b0, 1'b1, 5000);
    if (t_on !== AW'(40000) || t_off !== AW'(60000) || period !== PW'(100000) || valid !== 1'b1) begin
      failures++;
      $display("FAIL variable_dt_result: got on=%0d off=%0d per=%0d v=%b want 40000 60000 100000 1",
               t_on, t_off, period, valid);
    end
    checks++;
  endtask

  task automatic test_timeout();
    int lv[5]  = '{0, 1, 0, 1, 0};
    int len[5] = '{70, 30, 70, 30, 250};
    int rl[5]  = '{1, 0, 1, 0, 1};
    int rn[5]  = '{30, 70, 30, 70, 1};
    for (int ph = 0; ph < 5; ph++) begin
      for (int j = 0; j < len[ph]; j++) begin
        tick(1'b0, lv[ph][0], 10000);
        if (t_on !== AW'(m_t_on) || t_off !== AW'(m_t_off) || period !== PW'(m_period) ||
            valid !== m_valid || stuck !== m_stuck) begin
          failures++;
          $display("FAIL timeout cyc %0d: %s", cyc, got_want());
        end
        checks++;
        if (ph == 4 && (j == 199 || j == 200)) begin
          if (stuck !== (j == 200)) begin
            failures++;
            $display("FAIL timeout_edge low cycle %0d: got stuck=%b want %b", j + 1, stuck, (j == 200));
          end
          checks++;
        end
      end
    end
    if (t_on !== AW'(300000) || t_off !== AW'(700000) || period !== PW'(1000000) || stuck !== 1'b1) begin
      failures++;
      $display("FAIL timeout_hold: got on=%0d off=%0d per=%0d s=%b want 300000 700000 1000000 1",
               t_on, t_off, period, stuck);
    end
    checks++;
    // Resume PWM: stuck clears on the first transition, valid after one full period.
    for (int ph = 0; ph < 5; ph++) begin
      for (int j = 0; j < rn[ph]; j++) begin
        tick(1'b0, rl[ph][0], 10000);
        if (t_on !== AW'(m_t_on) || t_off !== AW'(m_t_off) || period !== PW'(m_period) ||
            valid !== m_valid || stuck !== m_stuck) begin
          failures++;
          $display("FAIL timeout_resume cyc %0d: %s", cyc, got_want());
        end
        checks++;
        if (ph == 0 && j == 0 && stuck !== 1'b0) begin
          failures++;
          $display("FAIL timeout_clear: got stuck=%b want 0", stuck);
        end
        if (ph == 0 && j == 0) checks++;
        if (valid !== ((ph == 2 || ph == 4) && j == 0)) begin
          failures++;
          $display("FAIL timeout_resume_valid ph%0d j%0d: got v=%b want %b", ph, j, valid,
                   ((ph == 2 || ph == 4) && j == 0));
        end
        checks++;
      end
    end
  endtask

  task automatic test_glitch();
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < 51; j++) begin
        tick(1'b0, (j == 50), 10000);
        if (t_on !== AW'(m_t_on) || t_off !== AW'(m_t_off) || period !== PW'(m_period) ||
            valid !== m_valid || stuck !== m_stuck) begin
          failures++;
          $display("FAIL glitch cyc %0d: %s", cyc, got_want());
        end
        checks++;
      end
    end
    if (t_on !== AW'(10000) || period !== PW'(510000) || valid !== 1'b1) begin
      failures++;
      $display("FAIL glitch_result: got on=%0d per=%0d v=%b want 10000 510000 1", t_on, period, valid);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    int lv[5]  = '{1, 0, 1, 0, 1};
    int len[5] = '{10, 30, 20, 30, 1};
    for (int j = 0; j < 10; j++) tick(1'b0, 1'b1, 10000);
    tick(1'b1, 1'b1, 10000);
    if (t_on !== '0 || t_off !== '0 || period !== '0 || valid !== 1'b0 || stuck !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_values: got on=%0d off=%0d per=%0d v=%b s=%b want all 0",
               t_on, t_off, period, valid, stuck);
    end
    checks++;
    for (int ph = 0; ph < 5; ph++) begin
      for (int j = 0; j < len[ph]; j++) begin
        tick(1'b0, lv[ph][0], 10000);
        if (valid !== (ph == 4)) begin
          failures++;
          $display("FAIL reset_mid_valid ph%0d j%0d: got v=%b want %b", ph, j, valid, (ph == 4));
        end
        checks++;
      end
    end
    if (t_on !== AW'(200000) || t_off !== AW'(300000) || period !== PW'(500000)) begin
      failures++;
      $display("FAIL reset_mid_result: got on=%0d off=%0d per=%0d want 200000 300000 500000",
               t_on, t_off, period);
    end
    checks++;
  endtask

  task automatic test_random();
    logic lv = 1'b0;
    for (int p = 0; p < 300; p++) begin
      int n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(150, 260))
                                          : int'($urandom_range(1, 20));
      lv = ~lv;
      for (int j = 0; j < n; j++) begin
        int d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 20000));
        tick(($urandom_range(0, 299) == 0), lv, d);
        if (t_on !== AW'(m_t_on) || t_off !== AW'(m_t_off) || period !== PW'(m_period) ||
            valid !== m_valid || stuck !== m_stuck) begin
          failures++;
          $display("FAIL random cyc %0d: %s", cyc, got_want());
        end
        checks++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_low_start();
    test_high_start();
    test_variable_dt();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
